// File: rtl/load_store_unit.sv
// Memory stage: turns ALU address + rs2 into one req/ack data-memory access and returns extended load data.
// Stalls the core from the start cycle until the access retires; flags misaligned/illegal accesses and bus timeouts.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  store_en,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    berr_q, berr_d;
  logic [31:0]             load_data_q, load_data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              lane_q, lane_d;

  logic        start;
  logic        f3_ok;
  logic        align_ok;
  logic        legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*lane +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Request decode; store_en takes priority when both enables are high.
  always_comb begin
    start    = load_en | store_en;
    f3_ok    = store_en ? (funct3 inside {3'b000, 3'b001, 3'b010})
                        : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    align_ok = 1'b1;
    case (funct3[1:0])
      2'b01:   align_ok = ~address[0];
      2'b10:   align_ok = (address[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal     = f3_ok & align_ok;
    req_be    = 4'b1111;
    req_wdata = store_data;
    if (store_en) begin
      case (funct3[1:0])
        2'b00: begin
          req_be    = 4'b0001 << address[1:0];
          req_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          req_be    = address[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{store_data[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    berr_d      = berr_q;
    load_data_d = load_data_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    stall       = 1'b0;
    done        = 1'b0;
    misaligned  = 1'b0;
    bus_error   = 1'b0;
    mem_req     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            stall   = 1'b1;
            addr_d  = {address[ADDR_WIDTH-1:2], 2'b00};
            we_d    = store_en;
            be_d    = req_be;
            wdata_d = req_wdata;
            f3_d    = funct3;
            lane_d  = address[1:0];
            cnt_d   = '0;
            berr_d  = 1'b0;
            state_d = WAIT_ACK;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        // An ack on the final allowed cycle still counts as success.
        if (mem_ack) begin
          if (!we_q) load_data_d = extract(f3_q, lane_q, mem_rdata);
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          if (!we_q) load_data_d = '0;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        bus_error = berr_q;
        cnt_d     = '0;
        berr_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      berr_q      <= 1'b0;
      load_data_q <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      berr_q      <= berr_d;
      load_data_q <= load_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
    end
  end

  assign load_data = load_data_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses against a behavioural model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clock;
  logic        reset;
  logic        load_en;
  logic        store_en;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ld_model;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .store_en(store_en),
    .funct3(funct3), .address(address), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    int size;
    if (st) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << f3[1:0];
    return ok && ((a % size) == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0, 3'd4: begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = v % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One complete access. wt = number of no-ack cycles before ack (>= TO means never ack).
  task automatic access(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int wt);
    bit legal;
    bit timed_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    bit acked;
    legal = model_legal(st, f3, a);
    exp_be = 4'hF;
    exp_wd = sd;
    if (st) begin
      if (f3 == 3'd0) begin exp_be = 4'(1 << (a % 4)); exp_wd = (sd % 256) * 32'h01010101; end
      if (f3 == 3'd1) begin exp_be = 4'(3 << (a % 4)); exp_wd = (sd % 65536) * 32'h00010001; end
    end
    @(negedge clock);
    load_en = ld; store_en = st; funct3 = f3; address = a; store_data = sd;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    if (!legal) begin
      check_eq("misaligned_flag", {31'd0, misaligned}, 32'd1);
      check_eq("misaligned_stall", {31'd0, stall}, 32'd0);
      check_eq("misaligned_req", {31'd0, mem_req}, 32'd0);
      @(posedge clock); #1;
      load_en = 0; store_en = 0; mem_ack = 0;
      @(negedge clock);
      check_eq("misaligned_no_req", {31'd0, mem_req}, 32'd0);
      check_eq("misaligned_load_data_hold", load_data, ld_model);
      return;
    end
    check_eq("start_stall", {31'd0, stall}, 32'd1);
    check_eq("start_misaligned", {31'd0, misaligned}, 32'd0);
    @(posedge clock); #1;
    load_en = 0; store_en = 0; mem_ack = 0;
    address = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    acked = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge clock);
      check_eq("wait_req", {31'd0, mem_req}, 32'd1);
      check_eq("wait_stall", {31'd0, stall}, 32'd1);
      check_eq("wait_done", {31'd0, done}, 32'd0);
      check_eq("wait_addr", mem_addr, a & ~32'd3);
      check_eq("wait_we", {31'd0, mem_we}, {31'd0, st});
      check_eq("wait_be", {28'd0, mem_be}, {28'd0, exp_be});
      if (st) check_eq("wait_wdata", mem_wdata, exp_wd);
      if (c == wt) begin mem_ack = 1; mem_rdata = rd; end
      else begin mem_ack = 0; mem_rdata = $urandom; end
      @(posedge clock); #1;
      mem_ack = 0;
      if (c == wt) begin acked = 1; break; end
    end
    timed_out = !acked;
    if (!st) ld_model = timed_out ? 32'd0 : model_load(f3, a, rd);
    @(negedge clock);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("done_bus_error", {31'd0, bus_error}, {31'd0, timed_out});
    check_eq("done_stall", {31'd0, stall}, 32'd0);
    check_eq("done_req", {31'd0, mem_req}, 32'd0);
    check_eq("done_load_data", load_data, ld_model);
    // Enables still high for the retiring instruction must not start a new access.
    load_en = ld; store_en = st; funct3 = f3; address = a;
    @(posedge clock); #1;
    load_en = 0; store_en = 0;
    @(negedge clock);
    check_eq("after_done", {29'd0, done, mem_req, stall}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1; load_en = 0; store_en = 0; funct3 = 0; address = 0; store_data = 0;
    mem_ack = 0; mem_rdata = 0; ld_model = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check_eq("reset_outputs", {25'd0, stall, done, misaligned, bus_error, mem_req, mem_we, 1'b0}, 32'd0);
    check_eq("reset_load_data", load_data, 32'd0);
    check_eq("reset_mem_addr", mem_addr, 32'd0);
    check_eq("reset_mem_be", {28'd0, mem_be}, 32'd0);
    check_eq("reset_mem_wdata", mem_wdata, 32'd0);

    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0);
    access(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 2);
    access(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 0);
    access(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 3);
    access(1, 0, 3'b010, 32'h102, 0, 0, 0);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0);
    access(1, 0, 3'b010, 32'h300, 0, 32'h12345678, TO);
    access(1, 1, 3'b100, 32'h400, 32'h55, 0, 0);

    // Reset in the middle of WAIT_ACK, followed by a late ack.
    @(negedge clock);
    load_en = 1; funct3 = 3'b010; address = 32'h500;
    @(posedge clock); #1 load_en = 0;
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    ld_model = 0;
    @(negedge clock);
    check_eq("rst_mid_state", {28'd0, done, bus_error, mem_req, stall}, 32'd0);
    check_eq("rst_mid_load_data", load_data, 32'd0);
    @(posedge clock); #1 mem_ack = 0;
    @(negedge clock);
    check_eq("rst_late_ack", {29'd0, done, bus_error, mem_req}, 32'd0);
    check_eq("rst_late_load_data", load_data, 32'd0);

    for (int i = 0; i < 300; i++) begin
      bit ld, st;
      int k;
      k = $urandom_range(0, 3);
      ld = (k != 1);
      st = (k != 0);
      access(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, TO + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory stage directly downstream of the ALU. It takes the ALU result as the effective address and the rs2 value as store data. It runs a req/ack transaction to data memory and returns sign- or zero-extended load data to writeback. It stalls the core's PC/register-file update while a transaction is outstanding and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, cycles in WAIT_ACK without mem_ack before bus_error; legal range 2..256
ADDR_WIDTH, 32, width of address and memory address bus

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
load_en  input  1  current instruction is a load
store_en  input  1  current instruction is a store; wins if load_en also high
funct3  input  3  instruction funct3 (size/signedness)
address  input  ADDR_WIDTH  effective address from ALU result
store_data  input  32  rs2 value, unshifted
stall  output  1  hold PC and register-file write this cycle
done  output  1  one-cycle pulse: access retired
load_data  output  32  extended load result
misaligned  output  1  one-cycle pulse: misaligned access or illegal funct3, no access issued
bus_error  output  1  one-cycle pulse coincident with done on timeout
mem_req  output  1  memory request
mem_we  output  1  1=write
mem_addr  output  ADDR_WIDTH  word address {address[ADDR_WIDTH-1:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes request this cycle
mem_rdata  input  32  read word, valid when mem_ack

Behaviour:
- Reset values: state=IDLE, all outputs 0, load_data=0, timeout counter=0.
- States: IDLE, WAIT_ACK, DONE.
- IDLE, start=(load_en|store_en):
  - Legal and aligned start: latch mem_addr, mem_we, mem_be, mem_wdata, funct3 and address[1:0]. Next state WAIT_ACK. stall=1 combinationally this cycle.
  - Misaligned or illegal start: misaligned=1 this cycle (combinational), stall=0, no request, stay IDLE.
- Misaligned: halfword with address[0]=1; word with address[1:0]!=0.
- Illegal funct3: loads 011/110/111; stores other than 000/001/010.
- WAIT_ACK:
  - mem_req=1, stall=1; request fields held stable until mem_ack.
  - Counter increments each cycle without ack.
  - mem_ack=1: load_data <= extracted mem_rdata if load (unchanged on store); next DONE.
  - Counter==TIMEOUT_CYCLES-1 and no ack: load_data <= 0 if load; bus_error flag set; next DONE.
  - Ack on the timeout cycle counts as success.
- DONE (exactly one cycle):
  - done=1, stall=0, mem_req=0; bus_error=1 if timed out.
  - load_en/store_en are ignored this cycle; they belong to the retiring instruction.
  - Next state IDLE; counter cleared.
- Latency: a zero-wait memory acks in the first WAIT_ACK cycle. Load data is then valid in DONE, 2 cycles after the IDLE start cycle.
- load_data holds its value until the next load completes.
- Load extraction, by funct3, using lane address[1:0]:
  - 000 sign-extend byte; 100 zero-extend byte.
  - 001 sign-extend halfword at lane 0 or 2; 101 zero-extend halfword.
  - 010 full word.
- Store lanes:
  - SB: be=4'b0001<<address[1:0], wdata={4{byte}}.
  - SH: be=0011 (address[1]=0) or 1100, wdata={2{half}}.
  - SW: be=1111, wdata=store_data.
- mem_be=4'b1111 for loads.
- mem_ack outside WAIT_ACK is ignored.
- Reset mid-transaction: next edge returns IDLE, mem_req drops, no done pulse; a late ack afterwards is ignored.

Test Plan:
- LW, address=0x100, memory acks after 0 waits, rdata=0xDEADBEEF -> mem_req 1 cycle, mem_addr=0x100, be=1111; done next cycle with load_data=0xDEADBEEF; stall high 2 cycles.
- LB at 0x103, rdata=0x80FF_1234 -> load_data=0xFFFFFF80. LBU same access -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201, store_data=0x000000AB -> mem_we=1, mem_addr=0x200, be=0010, wdata=0xABABABAB. SH at 0x202, 0x1234 -> be=1100, wdata=0x12341234.
- LW at 0x102 -> misaligned=1 same cycle, stall=0, mem_req never asserted. Load funct3=011 -> misaligned=1.
- TIMEOUT_CYCLES=4, LW, no ack -> mem_req high 4 cycles, then done=1 with bus_error=1 and load_data=0.
- Reset asserted during WAIT_ACK, then mem_ack one cycle after reset -> mem_req=0 after the reset edge, no done/bus_error, state IDLE, load_data=0.
